// File: rtl/poly_mod_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : poly_mod_pkg                                                   |
// | Shared types and default geometry for the polynomial modular datapath.   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
package poly_mod_pkg;

  // Default operand geometry; matches the multiplier instance in the parent
  localparam int DEF_WORD_BITS       = 8;
  localparam int DEF_NUM_WORDS       = 4;
  localparam int DEF_REDUN_WORD_BITS = 1;
  localparam int DEF_I_WORD          = DEF_NUM_WORDS + 1;
  localparam int DEF_COEF_BITS       = DEF_WORD_BITS + DEF_REDUN_WORD_BITS;
  localparam int DEF_ITER_BITS       = 32;

  // Redundant-form operand: I_WORD coefficients, each with carry headroom
  typedef logic [DEF_I_WORD-1:0][DEF_COEF_BITS-1:0] redun_t;

  // Squaring-loop sequencer states
  typedef enum logic [2:0] {
    DRAIN = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/poly_sq_loop_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : poly_sq_loop_ctrl_if                                         |
// | Start/result handshakes and multiplier issue/return path of the          |
// | squaring-loop sequencer. Signal names are from the sequencer's view.     |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
interface poly_sq_loop_ctrl_if
  import poly_mod_pkg::*;
#(
  parameter int I_WORD    = DEF_I_WORD,
  parameter int COEF_BITS = DEF_COEF_BITS,
  parameter int ITER_BITS = DEF_ITER_BITS
);
  localparam int DAT_W = I_WORD * COEF_BITS;

  // Start request
  logic                 i_val;
  logic                 o_rdy;
  logic [DAT_W-1:0]     i_dat;
  logic [ITER_BITS-1:0] i_iter;
  // Multiplier issue and return
  logic                 o_mul_val;
  logic [DAT_W-1:0]     o_mul_dat;
  logic                 i_mul_val;
  logic [DAT_W-1:0]     i_mul_dat;
  // Result
  logic                 o_val;
  logic                 i_rdy;
  logic [DAT_W-1:0]     o_dat;
  logic [ITER_BITS-1:0] o_iter_cnt;
  logic                 o_err;

  // Parent side: issues jobs, hosts the multiplier, consumes results
  modport master (
    output i_val, i_dat, i_iter, i_mul_val, i_mul_dat, i_rdy,
    input  o_rdy, o_mul_val, o_mul_dat, o_val, o_dat, o_iter_cnt, o_err
  );

  // Sequencer side
  modport slave (
    input  i_val, i_dat, i_iter, i_mul_val, i_mul_dat, i_rdy,
    output o_rdy, o_mul_val, o_mul_dat, o_val, o_dat, o_iter_cnt, o_err
  );

endinterface
`default_nettype wire

// File: rtl/poly_sq_loop_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : poly_sq_loop_ctrl                                               |
// | Runs N back-to-back modular squarings on an external multiplier, feeding |
// | each result straight back, and returns the final value on a handshake.   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module poly_sq_loop_ctrl
  import poly_mod_pkg::*;
#(
  parameter int WORD_BITS       = DEF_WORD_BITS,
  parameter int NUM_WORDS       = DEF_NUM_WORDS,
  parameter int REDUN_WORD_BITS = DEF_REDUN_WORD_BITS,
  parameter int MUL_LATENCY     = 6,
  parameter int ITER_BITS       = DEF_ITER_BITS,
  parameter int TIMEOUT         = 4
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  poly_sq_loop_ctrl_if.slave    bus
);

  localparam int I_WORD     = NUM_WORDS + 1;
  localparam int COEF_BITS  = WORD_BITS + REDUN_WORD_BITS;
  localparam int DAT_W      = I_WORD * COEF_BITS;
  localparam int WDOG_LIMIT = MUL_LATENCY + TIMEOUT - 1;
  localparam int WDOG_W     = $clog2(MUL_LATENCY + TIMEOUT + 1);
  localparam int DRAIN_W    = $clog2(MUL_LATENCY + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DAT_W-1:0]     r_dat;
  logic [ITER_BITS-1:0] r_iter;
  logic [ITER_BITS-1:0] r_cnt;
  logic [WDOG_W-1:0]    r_wdog;
  logic [DRAIN_W-1:0]   r_drain;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_issue;
  logic                 w_result;
  logic                 w_timeout;
  logic                 w_spurious;
  logic [DAT_W-1:0]     w_mul_dat;
  logic [ITER_BITS:0]   w_cnt_inc;
  logic                 w_more;

  // One extra bit keeps cnt+1 < N exact at N = 2^ITER_BITS-1
  assign w_cnt_inc = {1'b0, r_cnt} + (ITER_BITS + 1)'(1);
  assign w_more    = w_cnt_inc < {1'b0, r_iter};

  // State register; reset lands in DRAIN so stale multiplier results are flushed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= DRAIN;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_result    = 1'b0;
    w_timeout   = 1'b0;
    w_spurious  = 1'b0;
    w_mul_dat   = r_dat;
    case (r_state)
      DRAIN: begin
        if (r_drain == DRAIN_W'(MUL_LATENCY - 1)) w_state_nxt = IDLE;
      end
      IDLE: begin
        w_spurious = bus.i_mul_val;
        if (bus.i_val) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.i_iter == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        w_spurious  = bus.i_mul_val;
        w_issue     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.i_mul_val) begin
          w_result = 1'b1;
          if (w_more) begin
            // Feed the result straight back so the multiplier never idles
            w_issue   = 1'b1;
            w_mul_dat = bus.i_mul_dat;
          end else begin
            w_state_nxt = DONE;
          end
        end else if (r_wdog == WDOG_W'(WDOG_LIMIT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DONE: begin
        w_spurious = bus.i_mul_val;
        if (bus.i_rdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = DRAIN;
    endcase
  end

  assign bus.o_rdy      = (r_state == IDLE);
  assign bus.o_mul_val  = w_issue;
  assign bus.o_mul_dat  = w_mul_dat;
  assign bus.o_val      = (r_state == DONE);
  assign bus.o_dat      = r_dat;
  assign bus.o_iter_cnt = r_cnt;
  assign bus.o_err      = r_err;

  // Drain counter: runs only while in DRAIN, restarts on every entry
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 r_drain <= '0;
    else if (r_state == DRAIN) r_drain <= r_drain + DRAIN_W'(1);
    else                       r_drain <= '0;
  end

  // Job registers: start value then final result share r_dat
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dat  <= '0;
      r_iter <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_dat  <= bus.i_dat;
      r_iter <= bus.i_iter;
      r_cnt  <= '0;
    end else if (w_result) begin
      r_cnt <= w_cnt_inc[ITER_BITS-1:0];
      if (!w_more) r_dat <= bus.i_mul_dat;
    end
  end

  // Watchdog: cycles since the most recent issue while waiting for a result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_wdog <= '0;
    else if (w_issue)         r_wdog <= '0;
    else if (r_state == WAIT) r_wdog <= r_wdog + WDOG_W'(1);
  end

  // Sticky error; a fault in the same cycle as a start still reports
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                        r_err <= 1'b0;
    else if (w_spurious || w_timeout) r_err <= 1'b1;
    else if (w_accept)                r_err <= 1'b0;
  end

endmodule
`default_nettype wire
